// File: rtl/mod4_counter.sv
// mod4_counter: free-running unsigned up counter used as a sequence/timebase
// source. The count advances once per rising clk edge and returns to zero
// after MODULUS-1. A low level on rst clears the count at once, without
// waiting for a clock edge, and holds it at zero.
module mod4_counter #(
  parameter int unsigned     WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] cnt
);

  // Terminal count. MODULUS is held in 64 bits so that WIDTH=32 with the
  // default modulus of 2**32 can still be expressed.
  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 64'd1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);
  localparam logic [WIDTH-1:0] ZERO = WIDTH'(1'b0);

  logic [WIDTH-1:0] cnt_r;
  logic [WIDTH-1:0] cnt_next_s;

  // Next count: wrap at the modulus boundary, otherwise step by one.
  always_comb begin
    cnt_next_s = cnt_r;
    if (cnt_r == LAST) begin
      cnt_next_s = ZERO;
    end else begin
      cnt_next_s = cnt_r + ONE;
    end
  end

  // Count register with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= ZERO;
    end else begin
      cnt_r <= cnt_next_s;
    end
  end

  // The output comes straight from the register, with no logic in between.
  assign cnt = cnt_r;

endmodule

// File: tb/tb_mod4_counter.sv
// tb_mod4_counter: two instances (default modulus 16 and modulus 10) share
// clk and rst. The reference is the number of clock edges seen with rst high
// since the last reset, reduced modulo the instance's modulus.
`timescale 1ns/100ps
module tb_mod4_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cnt_a;
  logic [3:0] cnt_b;

  int checks = 0;
  int errors = 0;
  int n      = 0;   // counting edges since the last reset release

  mod4_counter #(.WIDTH(4)) dut_a (
    .clk(clk),
    .rst(rst),
    .cnt(cnt_a)
  );

  mod4_counter #(.WIDTH(4), .MODULUS(64'd10)) dut_b (
    .clk(clk),
    .rst(rst),
    .cnt(cnt_b)
  );

  // 2-unit clock period; rising edges at t = 1, 3, 5, ...
  always #1 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one clock edge, update the model and compare both counters on
  // the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst) n++;
    else     n = 0;
    @(negedge clk);
    check_eq("a_seq", {28'd0, cnt_a}, 32'(n % 16));
    check_eq("b_seq", {28'd0, cnt_b}, 32'(n % 10));
    check_eq("b_range", {31'd0, (cnt_b < 4'd10)}, 32'd1);
  endtask

  initial begin
    int hold;

    // Power-up: held in reset for more than 5 time units.
    #0.5;
    check_eq("por_a", {28'd0, cnt_a}, 32'd0);
    check_eq("por_b", {28'd0, cnt_b}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      check_eq("por_hold_a", {28'd0, cnt_a}, 32'd0);
      check_eq("por_hold_b", {28'd0, cnt_b}, 32'd0);
    end

    // Release between edges, then count 40 cycles.
    rst = 1'b1;
    n   = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (i == 1)  check_eq("release_first", {28'd0, cnt_a}, 32'd1);
      if (i == 15) check_eq("edge15", {28'd0, cnt_a}, 32'd15);
      if (i == 16) check_eq("wrap0", {28'd0, cnt_a}, 32'd0);
      if (i == 17) check_eq("wrap1", {28'd0, cnt_a}, 32'd1);
      if (i == 10) check_eq("b_wrap0", {28'd0, cnt_b}, 32'd0);
    end
    check_eq("run40", {28'd0, cnt_a}, 32'd8);

    // Async reset mid-count at 9.
    step();
    check_eq("pre_rst", {28'd0, cnt_a}, 32'd9);
    #0.5 rst = 1'b0;
    #0.2;
    check_eq("async_a", {28'd0, cnt_a}, 32'd0);
    check_eq("async_b", {28'd0, cnt_b}, 32'd0);
    repeat (3) begin
      step();
      check_eq("rst_hold", {28'd0, cnt_a}, 32'd0);
    end
    rst = 1'b1;
    step();
    check_eq("rst_release", {28'd0, cnt_a}, 32'd1);

    // Randomized run with occasional resets dropped between edges.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 15) == 0) begin
        #($urandom_range(1, 6) * 0.1);
        rst = 1'b0;
        #0.1;
        check_eq("rand_async_a", {28'd0, cnt_a}, 32'd0);
        check_eq("rand_async_b", {28'd0, cnt_b}, 32'd0);
        hold = int'($urandom_range(1, 4));
        repeat (hold) step();
        rst = 1'b1;
      end else begin
        step();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
